datapath_seq: RTL
=================

# datapath_seq

Parametrised, self-sequencing successor to the CPU datapath: register file, A/B operand registers, shifter, ALU, C result register and status register, with a built-in micro-sequencer. The controller issues one command per operation with a start/ready handshake, instead of driving per-cycle load strobes. Results write back automatically, and completion is signalled with a one-cycle `done` pulse. The block sits between the instruction decoder and the memory interface; `dp_out` feeds memory address and data paths.

## Interface
- `W`, default 16: datapath width in bits (≥ 4).
- `NREG`, default 8: number of general registers (power of two, ≥ 2); `RA` = $clog2(NREG).

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: command valid; accepted only when `ready` = 1.
- `ready` out 1: high exactly when the FSM is in IDLE.
- `op` in 3: operation code (see Operation).
- `rd`, `rn`, `rm` in RA each: destination, first source and second source register indices.
- `shift` in 2: shifter control applied to `reg[rm]`.
- `imm` in W: sign-extended immediate, supplied by the decoder.
- `mdata` in W: memory read data, sampled in EXEC.
- `done` out 1: one-cycle pulse while in WB.
- `dp_out` out W: C register contents.
- `status` out 3: {V, N, Z}.

## Operation
- On `start & ready`, `op`, `rd`, `rn`, `rm`, `shift` and `imm` are latched into a command register. `start` while not ready is ignored; it is neither queued nor an error.
- FSM states: IDLE → RDA → RDB → EXEC → WB → IDLE. All non-IDLE transitions are unconditional. Every op takes the full path.
- RDA: A ← `reg[rn]`.
- RDB: B ← `reg[rm]`.
- EXEC: C ← result. For CMP only, `status` ← flags.
- WB: `done` = 1. At the closing edge, `reg[rd]` ← C unless op is CMP.
- Shifter output S = `shift`(B):
  - 00: pass
  - 01: LSL 1, LSB filled with 0
  - 10: LSR 1, MSB filled with 0
  - 11: ASR 1, MSB replicated
- Ops:
  - 000 MOVI: imm
  - 001 MOV: S
  - 010 ADD: A+S
  - 011 CMP: A−S, no writeback
  - 100 AND: A&S
  - 101 MVN: ~S
  - 110 LDM: `mdata`
  - 111 ADDI: A+imm
- Arithmetic is modulo 2^W; carry-out is discarded.
- Flags on CMP:
  - Z = (result == 0)
  - N = result[W−1]
  - V = signed overflow of A−S, i.e. A and S signs differ and the result sign differs from A
- Register reads are combinational from the array; writes are synchronous. rd may equal rn and/or rm.

## Timing
- Reset values: state IDLE, `ready` 1, `done` 0, `dp_out` 0, `status` 000, A = B = 0, all NREG registers 0.
- With the accepting edge as E0:
  - E1: A loaded.
  - E2: B loaded.
  - E3: C and status loaded; `done` high during the following cycle.
  - E4: register write; `ready` returns high.
- Latency from accept to `done` is 4 cycles. Throughput is one command per 5 cycles: `start` asserted in the first IDLE cycle after WB is accepted at the next edge.
- `dp_out` holds C until the next EXEC of a later command, so it remains valid after `done`.
- `status` changes only at the EXEC edge of a CMP, or on reset.
- `mdata` must be stable in the EXEC cycle. Only LDM uses it.
- Reset asserted in any state returns to IDLE at that edge. The pending writeback is aborted, and every register, including the file, clears.
- Command inputs changing after acceptance have no effect.

## Test plan
- Reset, then MOVI r3 = 0x1234 → `done` pulse exactly 4 cycles after accept, `dp_out` = 0x1234. Next op MOV r5 = r3 with shift 00 → `dp_out` = 0x1234.
- r1 = 0x7FFF, r2 = 0x0001, CMP r1, r2 with shift 01 → A−S = 0x7FFD, `status` = 000, r-file unchanged. r1 = 0x8000, CMP r1, r2 with shift 00 → result 0x7FFF, `status` = {V=1, N=0, Z=0}.
- r4 = 0x8002: MOV shift 10 → 0x4001; shift 11 → 0xC001; shift 01 → 0x0004.
- ADD r0 = r0 + r0 with r0 = 0x8000 → wraps to 0x0000, `status` unchanged (not CMP), r0 = 0.
- `start` held high continuously → commands accepted every 5 cycles only, `ready` low for 4 cycles after each accept. Assert `reset` during EXEC of LDM r6 (`mdata` = 0xBEEF) → no `done`, r6 = 0, `ready` = 1 on the next cycle.
- Re-run with W = 8, NREG = 4: ADDI r3 = r3 + 0xFF (−1) starting from r3 = 0x00 → 0xFF. CMP 0x80 − 0x01 → V = 1.

Source files
------------

// File: rtl/datapath_seq.sv
// Self-sequencing datapath: register file, A/B operand registers, shifter, ALU,
// C result register and status flags, driven by a fixed five-state micro-sequencer.
module datapath_seq #(
  parameter int W    = 16,
  parameter int NREG = 8,
  localparam int RA  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          ready,
  input  logic [2:0]    op,
  input  logic [RA-1:0] rd,
  input  logic [RA-1:0] rn,
  input  logic [RA-1:0] rm,
  input  logic [1:0]    shift,
  input  logic [W-1:0]  imm,
  input  logic [W-1:0]  mdata,
  output logic          done,
  output logic [W-1:0]  dp_out,
  output logic [2:0]    status
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_CMP  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVN  = 3'b101;
  localparam logic [2:0] OP_LDM  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  // Current sequencer state; kept as a named signal so checkers can bind to it.
  state_t state;

  // Latched command
  logic [2:0]    cmd_op;
  logic [RA-1:0] cmd_rd;
  logic [RA-1:0] cmd_rn;
  logic [RA-1:0] cmd_rm;
  logic [1:0]    cmd_shift;
  logic [W-1:0]  cmd_imm;

  // Datapath registers
  logic [W-1:0] regs [NREG];
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [W-1:0] c_reg;
  logic [2:0]   status_reg;
  logic         ready_reg;
  logic         done_reg;

  // Combinational datapath
  logic [W-1:0] rn_data;
  logic [W-1:0] rm_data;
  logic [W-1:0] shift_out;
  logic [W-1:0] sum_as;
  logic [W-1:0] diff_as;
  logic [W-1:0] sum_ai;
  logic [W-1:0] alu_out;
  logic         flag_v;
  logic         flag_n;
  logic         flag_z;

  assign rn_data = regs[cmd_rn];
  assign rm_data = regs[cmd_rm];

  always_comb begin
    shift_out = b_reg;
    case (cmd_shift)
      2'b00: shift_out = b_reg;
      2'b01: shift_out = {b_reg[W-2:0], 1'b0};
      2'b10: shift_out = {1'b0, b_reg[W-1:1]};
      2'b11: shift_out = {b_reg[W-1], b_reg[W-1:1]};
      default: shift_out = b_reg;
    endcase
  end

  // Carry-out of every adder is dropped: arithmetic wraps modulo 2^W.
  assign sum_as  = a_reg + shift_out;
  assign diff_as = a_reg - shift_out;
  assign sum_ai  = a_reg + cmd_imm;

  always_comb begin
    alu_out = '0;
    case (cmd_op)
      OP_MOVI: alu_out = cmd_imm;
      OP_MOV:  alu_out = shift_out;
      OP_ADD:  alu_out = sum_as;
      OP_CMP:  alu_out = diff_as;
      OP_AND:  alu_out = a_reg & shift_out;
      OP_MVN:  alu_out = ~shift_out;
      OP_LDM:  alu_out = mdata;
      OP_ADDI: alu_out = sum_ai;
      default: alu_out = '0;
    endcase
  end

  // Signed overflow of A-S: operand signs differ and the result sign left A's.
  assign flag_z = (diff_as == '0);
  assign flag_n = diff_as[W-1];
  assign flag_v = (a_reg[W-1] != shift_out[W-1]) && (diff_as[W-1] != a_reg[W-1]);

  // Handshake: a command is taken on the rising edge where start && ready;
  // ready is high only in IDLE, start at any other time is dropped, and done
  // pulses for exactly one cycle (WB) per accepted command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ready_reg  <= 1'b1;
      done_reg   <= 1'b0;
      cmd_op     <= '0;
      cmd_rd     <= '0;
      cmd_rn     <= '0;
      cmd_rm     <= '0;
      cmd_shift  <= '0;
      cmd_imm    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      status_reg <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cmd_op    <= op;
            cmd_rd    <= rd;
            cmd_rn    <= rn;
            cmd_rm    <= rm;
            cmd_shift <= shift;
            cmd_imm   <= imm;
            ready_reg <= 1'b0;
            state     <= S_RDA;
          end
        end
        S_RDA: begin
          a_reg <= rn_data;
          state <= S_RDB;
        end
        S_RDB: begin
          b_reg <= rm_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          c_reg <= alu_out;
          if (cmd_op == OP_CMP) begin
            status_reg <= {flag_v, flag_n, flag_z};
          end
          done_reg <= 1'b1;
          state    <= S_WB;
        end
        S_WB: begin
          if (cmd_op != OP_CMP) begin
            regs[cmd_rd] <= c_reg;
          end
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign ready  = ready_reg;
  assign done   = done_reg;
  assign dp_out = c_reg;
  assign status = status_reg;

endmodule
